aib_clk_rst_seq: RTL and testbench

Parametrised reset-sequencing and clock-division controller for the AIB top level. It is the next generation of the top-level control block: instead of passing reset straight through and hard-wiring a divide-by-2 bus clock, it synchronises reset release and deasserts `NUM_RST` reset domains in order, with a programmable delay between domains. It also generates a programmable even-ratio divided clock whose ratio can be changed glitch-free at run time.

---
 rtl/aib_clk_rst_seq.sv | 152 +++++++++++++++
 tb/tb_aib_clk_rst_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_clk_rst_seq.sv
// AIB top-level reset sequencer and glitch-free programmable even-ratio
// clock divider. Reset domains release in order with a programmable gap.
module aib_clk_rst_seq #(
    parameter int NUM_RST = 3,
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [CNT_W-1:0]   i_cfg_dly,
    input  logic [DIV_W-1:0]   i_cfg_div,
    input  logic               i_cfg_chg,
    output logic [NUM_RST-1:0] o_rst_n,
    output logic               o_div_clk,
    output logic               o_div_pls,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_ack
);

    localparam int K_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_RST - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REL,
        DONE
    } state_t;

    logic rst_meta;
    logic rst_s_n;

    // Assert asynchronously, release two edges after i_rst_n rises
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta <= 1'b0;
            rst_s_n  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_s_n  <= rst_meta;
        end
    end

    state_t           state;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] dly_cnt;

    always_ff @(posedge i_clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state   <= IDLE;
            k       <= '0;
            dly_cnt <= '0;
            o_rst_n <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else if (!i_en) begin
            state   <= IDLE;
            k       <= '0;
            o_rst_n <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    k       <= '0;
                    dly_cnt <= i_cfg_dly;
                    o_busy  <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (dly_cnt == '0) begin
                        state <= REL;
                    end else begin
                        dly_cnt <= dly_cnt - CNT_W'(1);
                    end
                end
                REL: begin
                    o_rst_n[k] <= 1'b1;
                    if (k == K_LAST) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        k       <= k + K_W'(1);
                        dly_cnt <= i_cfg_dly;
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] next_ratio;
    logic             pend;
    logic             run;
    logic             wrap;
    logic             apply;

    // A request landing on the apply edge wins over the older shadow value
    always_comb begin
        run        = o_rst_n[0];
        wrap       = (phase == ratio);
        next_ratio = i_cfg_chg ? i_cfg_div : shadow;
        apply      = pend && (!run || (wrap && o_div_clk));
    end

    always_ff @(posedge i_clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            ratio     <= '0;
            shadow    <= '0;
            phase     <= '0;
            pend      <= 1'b0;
            o_div_clk <= 1'b0;
            o_div_pls <= 1'b0;
            o_cfg_ack <= 1'b0;
        end else begin
            o_div_pls <= 1'b0;
            o_cfg_ack <= 1'b0;
            if (i_cfg_chg) begin
                shadow <= i_cfg_div;
                pend   <= 1'b1;
            end
            if (apply) begin
                ratio     <= next_ratio;
                pend      <= 1'b0;
                o_cfg_ack <= 1'b1;
            end
            if (!run) begin
                phase     <= '0;
                o_div_clk <= 1'b0;
            end else if (wrap) begin
                phase     <= '0;
                o_div_clk <= ~o_div_clk;
                o_div_pls <= ~o_div_clk;
            end else begin
                phase <= phase + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aib_clk_rst_seq.sv
// Directed bench for aib_clk_rst_seq: reset sequencing, abort,
// divider ratios and glitch-free ratio changes.
module tb_aib_clk_rst_seq;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_en;
    logic [7:0] i_cfg_dly;
    logic [3:0] i_cfg_div;
    logic       i_cfg_chg;
    logic [2:0] o_rst_n;
    logic       o_div_clk;
    logic       o_div_pls;
    logic       o_busy;
    logic       o_done;
    logic       o_cfg_ack;

    int n_checks = 0;
    int n_fail   = 0;

    aib_clk_rst_seq #(
        .NUM_RST(3),
        .CNT_W  (8),
        .DIV_W  (4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_cfg_dly(i_cfg_dly),
        .i_cfg_div(i_cfg_div),
        .i_cfg_chg(i_cfg_chg),
        .o_rst_n  (o_rst_n),
        .o_div_clk(o_div_clk),
        .o_div_pls(o_div_pls),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_cfg_ack(o_cfg_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        logic [7:0] outs;
        logic [4:0] got, exp;
        i_rst_n   = 1'b0;
        i_en      = 1'b0;
        i_cfg_dly = 8'd4;
        i_cfg_div = 4'd0;
        i_cfg_chg = 1'b0;
        repeat (3) @(negedge i_clk);
        outs = {o_rst_n, o_div_clk, o_div_pls, o_busy, o_done, o_cfg_ack};
        n_checks++;
        if (outs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vals got=%b exp=%b", outs, 8'h00);
        end
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        i_en = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge i_clk);
            got = {o_rst_n, o_busy, o_done};
            exp = {(j >= 6) ? 3'b001 : 3'b000, 1'b1, 1'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid j=%0d got=%b exp=%b", j, got, exp);
            end
        end
        #2 i_rst_n = 1'b0;
        #1;
        outs = {o_rst_n, o_div_clk, o_div_pls, o_busy, o_done, o_cfg_ack};
        n_checks++;
        if (outs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async got=%b exp=%b", outs, 8'h00);
        end
        i_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        i_en = 1'b1;
        for (int j = 0; j <= 19; j++) begin
            @(negedge i_clk);
            got = {o_rst_n, o_busy, o_done};
            exp[4:2] = (j >= 18) ? 3'b111 : (j >= 12) ? 3'b011 :
                       (j >= 6) ? 3'b001 : 3'b000;
            exp[1]   = (j < 18);
            exp[0]   = (j >= 18);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_seq j=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_zero_delay();
        logic [4:0] got, exp;
        i_en = 1'b0;
        @(negedge i_clk);
        got = {o_rst_n, o_busy, o_done};
        n_checks++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL zd_clear got=%b exp=%b", got, 5'b0);
        end
        i_cfg_dly = 8'd0;
        i_en      = 1'b1;
        for (int j = 0; j <= 7; j++) begin
            @(negedge i_clk);
            got = {o_rst_n, o_busy, o_done};
            exp[4:2] = (j >= 6) ? 3'b111 : (j >= 4) ? 3'b011 :
                       (j >= 2) ? 3'b001 : 3'b000;
            exp[1]   = (j < 6);
            exp[0]   = (j >= 6);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL zero_dly j=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] got, exp;
        i_en = 1'b0;
        @(negedge i_clk);
        i_cfg_dly = 8'd2;
        i_en      = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            @(negedge i_clk);
            got = {o_rst_n, o_busy, o_done};
            if (j >= 8)
                exp = 5'b000_0_0;
            else if (j >= 4)
                exp = 5'b001_1_0;
            else
                exp = 5'b000_1_0;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort j=%0d got=%b exp=%b", j, got, exp);
            end
            if (j == 7) i_en = 1'b0;
        end
        i_en = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            @(negedge i_clk);
            got = {o_rst_n, o_busy, o_done};
            exp = (j >= 4) ? 5'b001_1_0 : 5'b000_1_0;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL restart j=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_divider();
        logic [1:0] got, exp;
        i_en = 1'b0;
        repeat (2) @(negedge i_clk);
        i_cfg_dly = 8'd0;
        i_en      = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            @(negedge i_clk);
            got    = {o_div_clk, o_div_pls};
            exp[1] = (j >= 3) && (((j - 3) % 2) == 0);
            exp[0] = exp[1];
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL div_r0 j=%0d got=%b exp=%b", j, got, exp);
            end
        end
        i_en = 1'b0;
        repeat (2) @(negedge i_clk);
        i_cfg_div = 4'd3;
        i_cfg_chg = 1'b1;
        for (int j = 0; j <= 2; j++) begin
            @(negedge i_clk);
            i_cfg_chg = 1'b0;
            n_checks++;
            if (o_cfg_ack !== (j == 1)) begin
                n_fail++;
                $display("FAIL idle_ack j=%0d got=%b exp=%b",
                         j, o_cfg_ack, (j == 1));
            end
        end
        i_en = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            @(negedge i_clk);
            got    = {o_div_clk, o_div_pls};
            exp[1] = (j >= 6) && ((((j - 6) / 4) % 2) == 0);
            exp[0] = (j >= 6) && (((j - 6) % 8) == 0);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL div_r3 j=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_glitch_free();
        logic [2:0] got, exp;
        bit found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge i_clk);
            if (o_div_pls === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL gf_wait_pls got=timeout exp=pulse");
        end
        i_cfg_div = 4'd1;
        i_cfg_chg = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge i_clk);
            if (j == 1) i_cfg_chg = 1'b0;
            got    = {o_div_clk, o_div_pls, o_cfg_ack};
            exp[2] = (j < 4) ? 1'b1 : ((((j - 4) / 2) % 2) == 1);
            exp[1] = (j == 6) || (j == 10);
            exp[0] = (j == 4);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL glitch_free j=%0d got=%b exp=%b", j, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        logic prev;
        bit found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            prev = o_div_clk;
            @(negedge i_clk);
            if (prev === 1'b1 && o_div_clk === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL b2b_wait_fall got=timeout exp=fall");
        end
        i_cfg_div = 4'd2;
        i_cfg_chg = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            @(negedge i_clk);
            got    = {o_div_clk, o_div_pls, o_cfg_ack};
            exp[2] = (j == 2) || (j == 3) || (j >= 10 && j <= 15);
            exp[1] = (j == 2) || (j == 10);
            exp[0] = (j == 4);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL double_req j=%0d got=%b exp=%b", j, got, exp);
            end
            if (j == 1) i_cfg_chg = 1'b0;
            if (j == 2) begin
                i_cfg_div = 4'd5;
                i_cfg_chg = 1'b1;
            end
            if (j == 3) i_cfg_chg = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_zero_delay();
        test_abort();
        test_divider();
        test_glitch_free();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
